// File: rtl/vga_plot_arbiter_if.sv
// Pixel-port arbitration bus: requester side (master) and arbiter side (slave).
interface vga_plot_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] rect_x;
    logic [7*NREQ-1:0] rect_y;
    logic [8*NREQ-1:0] rect_w;
    logic [7*NREQ-1:0] rect_h;
    logic [3*NREQ-1:0] rect_colour;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [1:0]        grant_id;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  done, busy, grant_id, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output done, busy, grant_id, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel port among NREQ
// rectangle-fill requesters; one pixel per clock in raster order.
// Optional macro FRAME_GATE_EN adds frame_tick and holds off grants until a
// frame boundary has been seen.
module vga_plot_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned XSCREEN = 160,
    parameter int unsigned YSCREEN = 120
) (
    input  logic CLOCK_50,
    input  logic resetn,
`ifdef FRAME_GATE_EN
    input  logic frame_tick,
`endif
    vga_plot_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    localparam logic [8:0] XLIM = 9'(XSCREEN);
    localparam logic [7:0] YLIM = 8'(YSCREEN);
    localparam logic [1:0] LAST = 2'(NREQ - 1);

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d, ptr_q, ptr_d;
    logic [7:0] x0_q, x0_d, w_q, w_d, cx_q, cx_d;
    logic [6:0] y0_q, y0_d, h_q, h_d, cy_q, cy_d;
    logic [2:0] col_q, col_d;

    logic       grant_ok;
    logic       found;
    logic [1:0] sel;
    logic [7:0] sel_x, sel_w;
    logic [6:0] sel_y, sel_h;
    logic [2:0] sel_c;
    logic [8:0] sum_x;
    logic [7:0] sum_y;

`ifdef FRAME_GATE_EN
    logic gate_q, gate_d;

    // Gate opens on a frame tick and closes once the requesters go quiet.
    always_comb begin
        gate_d = gate_q;
        if (frame_tick)
            gate_d = 1'b1;
        else if (state_q == S_IDLE && bus.req == '0)
            gate_d = 1'b0;
    end

    // Gate register.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) gate_q <= 1'b0;
        else         gate_q <= gate_d;
    end

    assign grant_ok = gate_q | frame_tick;
`else
    assign grant_ok = 1'b1;
`endif

    // Round-robin pick: first set req bit scanning from ptr, with its rectangle.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        sel_x = '0;
        sel_y = '0;
        sel_w = '0;
        sel_h = '0;
        sel_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && bus.req[j] && j == (32'(ptr_q) + k) % NREQ) begin
                    found = 1'b1;
                    sel   = 2'(j);
                    sel_x = bus.rect_x[8*j +: 8];
                    sel_y = bus.rect_y[7*j +: 7];
                    sel_w = bus.rect_w[8*j +: 8];
                    sel_h = bus.rect_h[7*j +: 7];
                    sel_c = bus.rect_colour[3*j +: 3];
                end
            end
        end
    end

    // Next-state logic: grant and latch in IDLE, raster walk in DRAW, advance ptr in DONE.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            S_IDLE: begin
                if (found && grant_ok) begin
                    grant_d = sel;
                    x0_d    = sel_x;
                    y0_d    = sel_y;
                    w_d     = sel_w;
                    h_d     = sel_h;
                    col_d   = sel_c;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = (sel_w != '0 && sel_h != '0) ? S_DRAW : S_DONE;
                end
            end
            S_DRAW: begin
                if (cx_q == w_q - 8'd1) begin
                    cx_d = '0;
                    cy_d = cy_q + 7'd1;
                    if (cy_q == h_q - 7'd1)
                        state_d = S_DONE;
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_DONE: begin
                ptr_d   = (grant_q == LAST) ? 2'd0 : grant_q + 2'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched rectangle and pixel counters.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    // Done pulse on the granted requester's bit.
    always_comb begin
        bus.done = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            bus.done[i] = (state_q == S_DONE) && (grant_q == 2'(i));
    end

    // Pixel address is widened so off-screen sums clip instead of wrapping.
    assign sum_x          = {1'b0, x0_q} + {1'b0, cx_q};
    assign sum_y          = {1'b0, y0_q} + {1'b0, cy_q};
    assign bus.vga_x      = sum_x[7:0];
    assign bus.vga_y      = sum_y[6:0];
    assign bus.vga_colour = col_q;
    assign bus.vga_plot   = (state_q == S_DRAW) && (sum_x < XLIM) && (sum_y < YLIM);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.grant_id   = grant_q;
endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single vga_adapter pixel-write port (x, y, colour, plot) among NREQ requesters, such as the background redraw, snake body draw, food draw and erase logic.
- Each requester asks for a solid-colour rectangle fill using a level req / pulsed done handshake.
- The arbiter grants requesters round-robin, latches the rectangle, and walks it out one pixel per CLOCK_50 cycle in raster order.
- It sits directly in front of vga_adapter and replaces per-FSM muxing of VGA_X/VGA_Y/VGA_COLOR/plot.

Parameters:
- NREQ, 3, number of requesters (2..4).
- XSCREEN, 160, screen width in pixels; x coordinates at or beyond this are clipped.
- YSCREEN, 120, screen height in pixels; y coordinates at or beyond this are clipped.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  reset.
- req  in  NREQ  per-requester request level; held high until the matching done pulse.
- rect_x  in  8*NREQ  packed top-left x; slice i belongs to requester i.
- rect_y  in  7*NREQ  packed top-left y.
- rect_w  in  8*NREQ  packed width in pixels (0..255).
- rect_h  in  7*NREQ  packed height in pixels (0..127).
- rect_colour  in  3*NREQ  packed fill colour.
- done  out  NREQ  one-cycle pulse on the granted requester's bit when its rectangle is finished.
- busy  out  1  high in DRAW and DONE.
- grant_id  out  2  index of the current or last granted requester.
- vga_x  out  8  pixel x to vga_adapter.
- vga_y  out  7  pixel y to vga_adapter.
- vga_colour  out  3  pixel colour to vga_adapter.
- vga_plot  out  1  pixel write strobe to vga_adapter.

Behaviour:
- Reset is resetn, synchronous, active-low; clock is CLOCK_50.
- Reset values:
  - state IDLE; busy=0, done=0, grant_id=0, vga_plot=0.
  - Latched rectangle registers 0; pixel counters cx=0, cy=0.
  - Round-robin pointer ptr=0.
- Reset asserted mid-draw aborts immediately. No done pulse is issued; the requester must re-request.
- FSM states are IDLE, DRAW, DONE.
- IDLE:
  - If any req bit is high, select the first set bit scanning ptr, ptr+1, ... (mod NREQ).
  - At the clock edge: grant_id<=g; latch x0, y0, w, h and colour from slice g; cx<=0, cy<=0.
  - Go to DRAW if w!=0 and h!=0; otherwise go to DONE.
- DRAW:
  - Each cycle vga_x=x0+cx and vga_y=y0+cy; the sums are computed 9-bit and 8-bit respectively, and the outputs are their low bits.
  - vga_colour = latched colour.
  - vga_plot = 1 only if the sums satisfy x<XSCREEN and y<YSCREEN. Clipped pixels still consume their cycle.
  - cx increments each cycle. When cx==w-1, cx<=0 and cy increments. When cx==w-1 and cy==h-1, go to DONE.
  - Exactly w*h DRAW cycles.
- DONE:
  - done[grant_id]=1 for this single cycle; vga_plot=0.
  - ptr<=(grant_id+1) mod NREQ.
  - Go to IDLE.
- The vga_* outputs are combinational from registered state/counters and are valid in the same cycle as vga_plot.
- Latency:
  - req high in IDLE at cycle t → first pixel at t+1.
  - done at t+1+w*h.
  - IDLE again at t+2+w*h.
  - Minimum one IDLE cycle between consecutive rectangles.
- Request rules:
  - A requester must drop req the cycle after done, or it is eligible again, at lowest priority.
  - Dropping req mid-draw is ignored: the rectangle completes and done still pulses.
  - Changes to rect_* after the grant edge have no effect.
- Simultaneous requests are resolved strictly by ptr; no requester starves.

Optional Feature:
- Macro: FRAME_GATE_EN.
- When defined:
  - Adds input port frame_tick (1 bit).
  - Internal gate_open flag is set by frame_tick and cleared on any IDLE cycle with req==0.
  - IDLE grants only when gate_open=1, so drawing bursts start on frame boundaries.
  - frame_tick while busy sets gate_open for after the current burst.
- When undefined: no frame_tick port; grants are ungated, as described in Behaviour.

Test Plan:
- Reset then single request:
  - Stimulus: req=001, rect (10,20) 3x2, colour 5.
  - Required: vga_plot high for exactly 6 cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with colour 5; done=001 one cycle later; busy low after.
- Round-robin:
  - Stimulus: req=111 held, each with a 1x1 rect; requesters drop req after their done.
  - Required: grant order 0,1,2; each done pulse 3 cycles apart.
  - Then reassert req=101 with ptr=0: grant order 0 then 2.
- Clipping:
  - Stimulus: rect (158,118) 4x4.
  - Required: plot high only at x∈{158,159}, y∈{118,119} (4 pixels); 16 DRAW cycles total; done still pulses.
- Zero size:
  - Stimulus: w=0, h=5.
  - Required: no plot; done 1 cycle after grant.
- Reset mid-draw:
  - Stimulus: rect 8x8; resetn low after 10 pixels.
  - Required: next cycle vga_plot=0, busy=0, no done pulse, ptr=0.
- FRAME_GATE_EN:
  - Stimulus: req=001 with no frame_tick for 50 cycles.
  - Required: no plot.
  - Then one frame_tick pulse: drawing starts the following cycle.
